serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder.sv | 87 ++++++++
 tb/tb_serial_adder.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial unsigned adder: accepts an operand pair, adds it LSB-first over WIDTH
// cycles, then presents the sum and carry with a valid/ready handshake.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sr_q, sum_q;
  logic             c_q, cout_q;
  logic [CNT_W-1:0] cnt_q;

  logic             ha1_s, ha1_c, ha2_s, ha2_c, c_d;
  logic [WIDTH-1:0] sum_d;

  // Full adder built from two half adders; the two carries can never both be set.
  assign ha1_s = a_q[0] ^ b_q[0];
  assign ha1_c = a_q[0] & b_q[0];
  assign ha2_s = ha1_s ^ c_q;
  assign ha2_c = ha1_s & c_q;
  assign c_d   = ha1_c | ha2_c;
  assign sum_d = {ha2_s, sr_q[WIDTH-1:1]};

  // The visible sum lives in its own register so it stays put while the next add runs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sr_q    <= '0;
      sum_q   <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q     <= a;
            b_q     <= b;
            c_q     <= 1'b0;
            cnt_q   <= '0;
            state_q <= RUN;
          end
        end
        RUN: begin
          a_q   <= a_q >> 1;
          b_q   <= b_q >> 1;
          sr_q  <= sum_d;
          c_q   <= c_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            sum_q   <= sum_d;
            cout_q  <= c_d;
            cnt_q   <= '0;
            state_q <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Directed bench for serial_adder at WIDTH = 8 with hand-computed expected results.
module tb_serial_adder;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a, b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             carry_out;

  int ncmp = 0;
  int nerr = 0;

  serial_adder #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .carry_out (carry_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Accept one pair, expect the result 8 edges after the accept edge, then retire it.
  task automatic run_op(input string tag, input logic [7:0] opa, input logic [7:0] opb,
                        input logic [7:0] es, input logic ec);
    int n;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    a = opa;
    b = opb;
    step();
    in_valid = 1'b0;
    chk({tag, "_busy"}, {31'd0, in_ready}, 32'd0);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd8);
    chk({tag, "_sum"}, {24'd0, sum}, {24'd0, es});
    chk({tag, "_cout"}, {31'd0, carry_out}, {31'd0, ec});
    step();
    chk({tag, "_retired"}, {30'd0, out_valid, in_ready}, 32'd1);
  endtask

  initial begin
    logic [7:0] pa[3];
    logic [7:0] pb[3];
    logic [7:0] ps[3];
    logic       pc[3];
    int         acc, got, last_t;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    step();
    step();
    rst = 1'b0;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_sum", {24'd0, sum}, 32'd0);
    chk("rst_cout", {31'd0, carry_out}, 32'd0);

    // IDLE with no request holds
    step();
    step();
    chk("idle_hold", {30'd0, out_valid, in_ready}, 32'd1);

    run_op("zero", 8'h00, 8'h00, 8'h00, 1'b0);
    run_op("ff_01", 8'hFF, 8'h01, 8'h00, 1'b1);
    run_op("ff_ff", 8'hFF, 8'hFF, 8'hFE, 1'b1);
    run_op("a5_5a", 8'hA5, 8'h5A, 8'hFF, 1'b0);

    // Backpressure: result must hold while out_ready is low
    out_ready = 1'b0;
    in_valid  = 1'b1; a = 8'h3C; b = 8'h0F;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", {31'd0, out_valid}, 32'd1);
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_sum", {24'd0, sum}, 32'h4B);
      chk("bp_cout", {31'd0, carry_out}, 32'd0);
      step();
    end
    out_ready = 1'b1;
    step();
    chk("bp_release", {30'd0, out_valid, in_ready}, 32'd1);

    // Inputs wiggling during RUN/DONE must be ignored; no accept on the retire edge
    in_valid = 1'b1; a = 8'h81; b = 8'h03;
    step();
    for (int i = 0; i < 8; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      step();
    end
    chk("ign_valid", {31'd0, out_valid}, 32'd1);
    chk("ign_sum", {24'd0, sum}, 32'h84);
    chk("ign_cout", {31'd0, carry_out}, 32'd0);
    step();
    chk("no_accept_on_retire", {30'd0, out_valid, in_ready}, 32'd1);
    in_valid = 1'b0;
    step();
    chk("idle_after_retire", {30'd0, out_valid, in_ready}, 32'd1);

    // Reset in the middle of RUN aborts without producing a result
    in_valid = 1'b1; a = 8'hAA; b = 8'h55;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
    chk("abort_out_valid", {31'd0, out_valid}, 32'd0);
    chk("abort_sum", {24'd0, sum}, 32'd0);
    chk("abort_cout", {31'd0, carry_out}, 32'd0);
    for (int i = 0; i < 10; i++) step();
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    run_op("after_abort", 8'h12, 8'h34, 8'h46, 1'b0);

    // Back-to-back streaming: one result every WIDTH+2 cycles
    pa[0] = 8'hFF; pb[0] = 8'h01; ps[0] = 8'h00; pc[0] = 1'b1;
    pa[1] = 8'h80; pb[1] = 8'h80; ps[1] = 8'h00; pc[1] = 1'b1;
    pa[2] = 8'h37; pb[2] = 8'h49; ps[2] = 8'h80; pc[2] = 1'b0;
    acc = 0; got = 0; last_t = -1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    for (int t = 0; t < 60 && got < 3; t++) begin
      if (out_valid) begin
        chk("b2b_sum", {24'd0, sum}, {24'd0, ps[got]});
        chk("b2b_cout", {31'd0, carry_out}, {31'd0, pc[got]});
        if (last_t >= 0) chk("b2b_period", t - last_t, WIDTH + 2);
        last_t = t;
        got++;
      end
      if (in_ready) begin
        if (acc < 3) begin
          a = pa[acc];
          b = pb[acc];
          acc++;
        end else begin
          in_valid = 1'b0;
        end
      end
      step();
    end
    in_valid = 1'b0;
    chk("b2b_count", got, 32'd3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
